// File: rtl/uart_rgb_pwm_ctrl_if.sv
// Byte handshake between the serial core and the PWM command controller.
// The controller uses the slave view; the serial core (or a bench) uses the master view.
interface uart_rgb_pwm_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/uart_rgb_pwm_ctrl.sv
// UART byte-command front end driving NCH PWM channels. Duties are double-buffered
// (shadow -> active) so an update only ever lands on a PWM period boundary.
module uart_rgb_pwm_ctrl #(
  parameter int NCH     = 3,
  parameter int PWM_W   = 8,
  parameter int TIMEOUT = 12000000
) (
  input  logic               hw_clk,
  input  logic               resetn,
  uart_rgb_pwm_ctrl_if.slave bus,
  output logic [NCH-1:0]     pwm_out,
  output logic               rx_overrun
);
  localparam int             TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT - 1);
  localparam int             ND     = PWM_W / 4;
  localparam logic [1:0]     DLAST  = 2'(ND - 1);
  localparam logic [7:0]     CH_END = 8'(8'h30 + NCH);
  localparam logic [7:0]     R_BAN  = 8'h50;
  localparam logic [7:0]     R_ACK  = 8'h4B;
  localparam logic [7:0]     R_NAK  = 8'h3F;

  typedef enum logic [2:0] {BANNER, IDLE, GET_CH, GET_HEX, RESP} state_e;

  state_e           state_q, state_d, cur;
  logic [7:0]       resp_q, resp_d, txd_q, txd_d;
  logic             txv_q, txv_d;
  logic [3:0]       ch_q, ch_d;
  logic [PWM_W-1:0] acc_q, acc_d, acc_nxt;
  logic [1:0]       dig_q, dig_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic [PWM_W-1:0] cnt_q;
  logic             hs, tmo_hit, wr_en, leg_en, in_cmd;
  logic [4:0]       nib;
  logic [NCH-1:0]   leg_msk, leg_val;

  // {valid, value} of an ASCII hex digit
  function automatic logic [4:0] hex_nib(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  assign hs      = txv_q & bus.tx_ready;
  assign nib     = hex_nib(bus.rx_data);
  assign acc_nxt = PWM_W'({acc_q, nib[3:0]});
  assign in_cmd  = (state_q == GET_CH) || (state_q == GET_HEX);
  assign tmo_hit = in_cmd && (tmo_q == TMAX);

  assign bus.tx_data  = txd_q;
  assign bus.tx_valid = txv_q;
  assign rx_overrun   = ovr_q;

  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      state_q <= BANNER;
      resp_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ch_q    <= '0;
      acc_q   <= '0;
      dig_q   <= '0;
      tmo_q   <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      dig_q   <= dig_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // An expired timeout turns the current cycle into an IDLE cycle, so a byte
  // arriving exactly then starts afresh instead of extending the old command.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    dig_d   = dig_q;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    leg_en  = 1'b0;
    cur     = tmo_hit ? IDLE : state_q;
    if (tmo_hit) state_d = IDLE;
    tmo_d = '0;
    if (in_cmd && !tmo_hit && !bus.rx_valid) tmo_d = tmo_q + 1'b1;

    case (cur)
      BANNER, RESP: begin
        if (bus.rx_valid) ovr_d = 1'b1;
        if (hs) state_d = IDLE;
      end
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data[7:3] == 5'b00110) begin
          leg_en  = 1'b1;
          resp_d  = R_ACK;
          state_d = RESP;
        end else if (bus.rx_data == 8'h53) begin
          state_d = GET_CH;
        end else if (bus.rx_data != 8'h0D && bus.rx_data != 8'h0A) begin
          resp_d  = R_NAK;
          state_d = RESP;
        end
      end
      GET_CH: if (bus.rx_valid) begin
        if (bus.rx_data >= 8'h30 && bus.rx_data < CH_END) begin
          ch_d    = bus.rx_data[3:0];
          dig_d   = '0;
          acc_d   = '0;
          state_d = GET_HEX;
        end else begin
          resp_d  = R_NAK;
          state_d = RESP;
        end
      end
      GET_HEX: if (bus.rx_valid) begin
        if (nib[4]) begin
          acc_d = acc_nxt;
          dig_d = dig_q + 1'b1;
          if (dig_q == DLAST) begin
            wr_en   = 1'b1;
            resp_d  = R_ACK;
            state_d = RESP;
          end
        end else begin
          acc_d   = '0;
          resp_d  = R_NAK;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so the banner appears one cycle
  // after reset release and tx_valid is low while reset is held.
  always_comb begin
    txv_d = (state_d == BANNER) || (state_d == RESP);
    txd_d = (state_d == BANNER) ? R_BAN : resp_d;
  end

  always_comb begin
    leg_msk = '0;
    leg_val = '0;
    for (int i = 0; i < NCH; i++) begin
      leg_msk[i] = leg_en && (i < 3);
      leg_val[i] = (i < 3) && bus.rx_data[i % 3];
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [PWM_W-1:0] shadow_q, active_q;
    logic             pwm_q;

    always_ff @(posedge hw_clk) begin
      if (!resetn) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (wr_en && ch_q == 4'(i)) shadow_q <= acc_nxt;
        else if (leg_msk[i])        shadow_q <= {PWM_W{leg_val[i]}};
        if (&cnt_q) active_q <= shadow_q;
        pwm_q <= (cnt_q < active_q);
      end
    end

    assign pwm_out[i] = pwm_q;
  end
endmodule

// File: tb/tb_uart_rgb_pwm_ctrl.sv
// Directed + randomized bench for uart_rgb_pwm_ctrl against a command-level reference model.
module tb_uart_rgb_pwm_ctrl;
  localparam int NCH = 3, PWM_W = 8, TIMEOUT = 16, PER = 1 << PWM_W;

  logic           hw_clk = 1'b0;
  logic           resetn = 1'b0;
  logic [NCH-1:0] pwm_out;
  logic           rx_overrun;

  uart_rgb_pwm_ctrl_if bus();

  uart_rgb_pwm_ctrl #(.NCH(NCH), .PWM_W(PWM_W), .TIMEOUT(TIMEOUT)) dut (
    .hw_clk(hw_clk), .resetn(resetn), .bus(bus.slave),
    .pwm_out(pwm_out), .rx_overrun(rx_overrun)
  );

  always #5 hw_clk = ~hw_clk;

  int vec = 0, errs = 0, cyc = 0;
  always @(posedge hw_clk) cyc <= cyc + 1;

  // reference model: command parser in terms of bytes and elapsed cycles
  int   mode, mch, mval, mnd, last_cyc;
  int   shadow_m[NCH];
  logic ovr_m;

  task automatic tick();
    @(posedge hw_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return b - "0";
    if (b >= "A" && b <= "F") return b - "A" + 10;
    if (b >= "a" && b <= "f") return b - "a" + 10;
    return -1;
  endfunction

  task automatic model_reset();
    mode = 0; ovr_m = 1'b0; last_cyc = cyc;
    for (int i = 0; i < NCH; i++) shadow_m[i] = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output int resp);
    int h;
    if (mode != 0 && (cyc - last_cyc) >= TIMEOUT) mode = 0;
    last_cyc = cyc;
    resp = 0;
    case (mode)
      0: if (b >= "0" && b <= "7") begin
           for (int c = 0; c < NCH && c < 3; c++) shadow_m[c] = b[c] ? PER - 1 : 0;
           resp = "K";
         end else if (b == "S") mode = 1;
         else if (b != 8'h0D && b != 8'h0A) resp = "?";
      1: if (b >= "0" && b < "0" + NCH) begin
           mch = b - "0"; mval = 0; mnd = 0; mode = 2;
         end else begin resp = "?"; mode = 0; end
      default: begin
        h = hexval(b);
        if (h >= 0) begin
          mval = mval * 16 + h; mnd++;
          if (mnd == PWM_W / 4) begin shadow_m[mch] = mval; resp = "K"; mode = 0; end
        end else begin resp = "?"; mode = 0; end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    int r;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    model_byte(b, r);
    if (r != 0) begin
      chk("resp_valid", bus.tx_valid, 1);
      chk("resp_data", bus.tx_data, r);
      bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0;
      chk("resp_release", bus.tx_valid, 0);
    end else begin
      chk("no_resp", bus.tx_valid, 0);
      if (bus.tx_valid) begin bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0; end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic measure();
    int hc[NCH];
    repeat (PER + 2) tick();
    for (int i = 0; i < NCH; i++) hc[i] = 0;
    repeat (PER) begin
      tick();
      for (int i = 0; i < NCH; i++) hc[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < NCH; i++) chk($sformatf("duty_ch%0d", i), hc[i], shadow_m[i]);
    chk("overrun", rx_overrun, ovr_m);
  endtask

  initial begin
    string hx;
    int    r, g;
    logic [7:0] b;
    hx = "0123456789abcdefABCDEF";
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    model_reset();

    // reset state, banner handshaked once with tx_ready tied high
    repeat (3) tick();
    chk("rst_txv", bus.tx_valid, 0);
    chk("rst_txd", bus.tx_data, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ovr", rx_overrun, 0);
    resetn = 1'b1;
    tick();
    chk("banner_v", bus.tx_valid, 1);
    chk("banner_d", bus.tx_data, 8'h50);
    tick();
    chk("banner_once", bus.tx_valid, 0);
    repeat (4) tick();
    chk("banner_once2", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;
    measure();

    // directed commands
    send_str("S180"); measure();
    send_str("5");    measure();
    send_str("0");    measure();
    send_str("S9");
    send_str("S0G");
    send_str("S1\n");
    send_str("S2a7"); measure();

    // timeout abandons a partial command silently
    send_str("S2F");
    repeat (TIMEOUT) tick();
    chk("tmo_silent", bus.tx_valid, 0);
    send_str("Z");
    // gap just under the limit keeps the command alive
    send_str("S1A");
    repeat (TIMEOUT - 2) tick();
    send_str("B");
    // gap exactly at the limit: the byte is treated as a fresh command byte
    send_str("S1C");
    repeat (TIMEOUT - 1) tick();
    send_str("D");
    measure();

    // randomized byte stream with random gaps
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3:    b = 8'($urandom_range(8'h30, 8'h37));
        4, 5:          b = "S";
        6, 7, 8, 9:    b = 8'($urandom_range(8'h30, 8'h33));
        10, 11, 12:    b = hx[$urandom_range(0, 21)];
        13:            b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        14:            b = 8'($urandom);
        default:       b = "G";
      endcase
      g = $urandom_range(0, 9);
      if (g == 8) repeat ($urandom_range(TIMEOUT - 2, TIMEOUT)) tick();
      else if (g == 7) repeat ($urandom_range(1, 3)) tick();
      send(b);
      if (n % 25 == 24) measure();
    end
    measure();

    // reset during a pending response
    bus.rx_data = "Z"; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    chk("pend_txv", bus.tx_valid, 1);
    resetn = 1'b0;
    tick();
    chk("midrst_txv", bus.tx_valid, 0);
    tick();
    resetn = 1'b1;
    model_reset();
    tick();
    chk("rebanner_v", bus.tx_valid, 1);
    chk("rebanner_d", bus.tx_data, 8'h50);
    chk("rst_clears_ovr", rx_overrun, 0);

    // byte arriving while the banner is still pending is dropped
    bus.rx_data = "3"; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    ovr_m = 1'b1;
    chk("ovr_set", rx_overrun, 1);
    chk("ovr_hold_d", bus.tx_data, 8'h50);
    bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0;
    chk("ovr_hs", bus.tx_valid, 0);
    repeat (3) tick();
    chk("ovr_no_resp", bus.tx_valid, 0);
    measure();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
